// File: rtl/cvxif_copro_responder.sv
// cvxif_copro_responder
// Coprocessor-side responder for the CV-X-IF custom-instruction port.
// It decodes custom-0 instructions and answers each issue request in the same
// cycle. Accepted instructions run in order: ADD, NOP and EXC complete at once,
// and MADD takes LatMulti cycles. Results leave through a small FIFO that uses
// a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   issue_valid_i/_ready_o issue handshake (transfer when both are high)
//   issue_instr_i          offloaded instruction word
//   issue_id_i             transaction id
//   issue_rs1_i/_rs2_i     source operands, valid with issue_valid_i
//   issue_accept_o         instruction recognised (only during a handshake)
//   issue_writeback_o      accepted instruction will write rd
//   result_valid_o/_ready_i result handshake (the head pops when both are high)
//   result_id_o/_data_o/_rd_o/_we_o/_exc_o/_exccode_o  fields of the FIFO head
//
// Handshake rule for both channels: a transfer happens on a rising clk_i edge
// where valid and ready are both high. Valid does not depend on ready. While
// valid is high and ready is low, the payload is held stable.
module cvxif_copro_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned IdWidth     = 2,
   parameter int unsigned ResultDepth = 2,
   parameter int unsigned LatMulti    = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               issue_valid_i,
   output logic               issue_ready_o,
   input  logic [31:0]        issue_instr_i,
   input  logic [IdWidth-1:0] issue_id_i,
   input  logic [XLEN-1:0]    issue_rs1_i,
   input  logic [XLEN-1:0]    issue_rs2_i,
   output logic               issue_accept_o,
   output logic               issue_writeback_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [IdWidth-1:0] result_id_o,
   output logic [XLEN-1:0]    result_data_o,
   output logic [4:0]         result_rd_o,
   output logic               result_we_o,
   output logic               result_exc_o,
   output logic [5:0]         result_exccode_o
);

   localparam int unsigned PtrW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
   localparam int unsigned CntW = $clog2(ResultDepth + 1);
   localparam int unsigned LatW = $clog2(LatMulti);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [XLEN-1:0]    data;
      logic [4:0]         rd;
      logic               we;
      logic               exc;
   } entry_t;

   // ---------------- decode ----------------
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       opcode_ok, recognised, is_add, is_nop, is_madd, is_exc, hs;
   logic       unused_instr_bits;

   assign funct3     = issue_instr_i[14:12];
   assign rd         = issue_instr_i[11:7];
   assign opcode_ok  = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'b0);
   assign is_add     = opcode_ok && (funct3 == 3'b000);
   assign is_nop     = opcode_ok && (funct3 == 3'b001);
   assign is_madd    = opcode_ok && (funct3 == 3'b010);
   assign is_exc     = opcode_ok && (funct3 == 3'b011);
   assign recognised = is_add | is_nop | is_madd | is_exc;
   // Register-source fields travel as operands and are not decoded here.
   assign unused_instr_bits = ^issue_instr_i[24:15];

   // ---------------- state ----------------
   state_e             state_q, state_d;
   logic [LatW-1:0]    lat_q, lat_d;
   logic [XLEN-1:0]    op_a_q, op_b_q;
   logic [IdWidth-1:0] madd_id_q;
   logic [4:0]         madd_rd_q;
   entry_t             mem_q [ResultDepth];
   logic [PtrW-1:0]    wptr_q, rptr_q;
   logic [CntW-1:0]    count_q;

   logic   madd_capture, madd_push, sc_push, push, pop;
   entry_t push_entry, head;

   assign hs                = issue_valid_i & issue_ready_o;
   assign issue_ready_o     = (state_q == IDLE) && (count_q < CntW'(ResultDepth));
   assign issue_accept_o    = hs & recognised;
   assign issue_writeback_o = issue_accept_o & (is_add | is_madd) & (rd != 5'd0);

   // FSM: MADD occupies the datapath for LatMulti cycles. No issue is taken
   // while BUSY, which keeps results in order and reserves a FIFO slot.
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      madd_capture = 1'b0;
      madd_push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (issue_accept_o && is_madd) begin
               state_d      = BUSY;
               lat_d        = LatW'(LatMulti - 1);
               madd_capture = 1'b1;
            end
         end
         BUSY: begin
            // The counter reaching 0 on this edge is the push edge.
            lat_d = lat_q - LatW'(1);
            if (lat_q == LatW'(1)) begin
               madd_push = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ADD/NOP/EXC push at the handshake edge. MADD pushes later, when issue is
   // blocked, so the two push sources never collide.
   assign sc_push = issue_accept_o & ~is_madd;
   assign push    = sc_push | madd_push;
   assign pop     = result_valid_o & result_ready_i;

   always_comb begin
      push_entry = '0;
      if (madd_push) begin
         push_entry.id   = madd_id_q;
         push_entry.data = op_a_q + op_b_q + op_a_q;
         push_entry.rd   = madd_rd_q;
         push_entry.we   = (madd_rd_q != 5'd0);
      end else begin
         push_entry.id   = issue_id_i;
         push_entry.data = is_add ? (issue_rs1_i + issue_rs2_i) : '0;
         push_entry.rd   = rd;
         push_entry.we   = issue_writeback_o;
         push_entry.exc  = is_exc;
      end
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(ResultDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         madd_id_q <= '0;
         madd_rd_q <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         for (int i = 0; i < int'(ResultDepth); i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         if (madd_capture) begin
            op_a_q    <= issue_rs1_i;
            op_b_q    <= issue_rs2_i;
            madd_id_q <= issue_id_i;
            madd_rd_q <= rd;
         end
         if (push) begin
            mem_q[wptr_q] <= push_entry;
            wptr_q        <= ptr_inc(wptr_q);
         end
         if (pop) rptr_q <= ptr_inc(rptr_q);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   assign head             = mem_q[rptr_q];
   assign result_valid_o   = (count_q != '0);
   assign result_id_o      = head.id;
   assign result_data_o    = head.data;
   assign result_rd_o      = head.rd;
   assign result_we_o      = head.we;
   assign result_exc_o     = head.exc;
   assign result_exccode_o = head.exc ? 6'd2 : 6'd0;

endmodule

// File: doc/cvxif_copro_responder.md
# cvxif_copro_responder

Coprocessor-side responder for the core's CV-X-IF custom-instruction port (the core is the issuer; this block is the far end). It decodes offloaded custom-0 instructions, answers each issue transaction in the same cycle, executes accepted instructions in order (one single-cycle class, one multi-cycle class), and returns results through a small result FIFO with a valid/ready handshake. It instantiates as the default coprocessor in 32-bit configurations that enable CV-X-IF.

## Interface

Parameters:
- XLEN, 32: operand/result width.
- IdWidth, 2: transaction id width, sized for 4 scoreboard entries.
- ResultDepth, 2: result FIFO entries; must be ≥1.
- LatMulti, 3: multi-cycle latency in cycles; must be ≥2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  responder can take an issue this cycle.
- issue_instr_i  in  32  offloaded instruction word.
- issue_id_i  in  IdWidth  transaction id.
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands (always valid with issue_valid_i).
- issue_accept_o  out  1  instruction recognised; combinational, qualified by handshake.
- issue_writeback_o  out  1  accepted instruction will write rd.
- result_valid_o  out  1  FIFO head valid.
- result_ready_i  in  1  core consumes head.
- result_id_o  out  IdWidth  id of the result.
- result_data_o  out  XLEN  result value.
- result_rd_o  out  5  destination register (instr[11:7]).
- result_we_o  out  1  register write enable.
- result_exc_o  out  1  exception flag.
- result_exccode_o  out  6  exception cause; 6'd2 when result_exc_o is set, else 0.

## Operation

- Decode (combinational, on issue_instr_i): opcode 7'b0001011 required; funct7 7'b0. funct3: 000 ADD (rs1+rs2, modulo 2^XLEN), 001 NOP (we=0, data=0), 010 MADD (rs1+rs2+rs1, modulo 2^XLEN, LatMulti cycles), 011 EXC (we=0, exc=1, exccode=2). Any other encoding: accept=0, writeback=0.
- issue_writeback_o = 1 only for ADD and MADD with rd ≠ 0.
- Issue handshake: issue_valid_i & issue_ready_o. Unaccepted instructions still complete the handshake and enqueue nothing.
- issue_ready_o = !busy & (count < ResultDepth), where busy means a MADD is in flight and count is the FIFO occupancy. This guarantees in-order results and a reserved FIFO slot for every in-flight op.
- ADD/NOP/EXC: the entry is pushed into the FIFO at the handshake edge.
- MADD: operands, id, and rd are latched at the handshake edge and the counter is loaded with LatMulti-1. The counter decrements each cycle. When it reaches 0 the entry is pushed and busy clears on that same edge.
- FIFO: circular buffer with read/write pointers that wrap at ResultDepth. Push and pop in the same cycle leave count unchanged. The head is popped when result_valid_o & result_ready_i.
- State machine: IDLE→BUSY on a MADD handshake; BUSY→IDLE on the push edge. There is no issue in BUSY.

## Timing

- Reset: issue_ready_o=1 (FIFO empty, idle). result_valid_o=0. result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o, result_exccode_o are all 0. Pointers, count, and counter are 0; state is IDLE.
- Issue response outputs are combinational from issue_instr_i, with 0 input→output register stages.
- ADD/NOP/EXC latency: a handshake at edge N gives result_valid_o=1 in cycle N+1.
- MADD latency: a handshake at edge N gives result_valid_o in cycle N+LatMulti. issue_ready_o=0 for cycles N+1 … N+LatMulti-1 and returns to 1 in cycle N+LatMulti if count<ResultDepth.
- FIFO full: issue_ready_o=0 until a pop edge. A pop at edge M gives issue_ready_o=1 in cycle M+1.
- Result outputs are held stable while result_valid_o & !result_ready_i.
- Reset asserted mid-operation: all state clears immediately (asynchronous). In-flight and queued results are discarded, with no output glitch after rst_ni rises.

## Test plan

- Reset, then ADD, id=1, rd=5, rs1=0x10, rs2=0x22, with result_ready_i=1 → accept=1 and writeback=1 in the handshake cycle. Next cycle: result_valid_o=1, data=0x32, rd=5, we=1, id=1.
- MADD, rs1=0xFFFF_FFFF, rs2=2, with LatMulti=3 → issue_ready_o=0 for 2 cycles. Result valid 3 cycles after the handshake with data=0x0000_0000 (wrap); ready returns the same cycle.
- Instruction with opcode 7'b0110011 → accept=0 and writeback=0, the handshake completes, and result_valid_o stays 0.
- EXC, id=2 → result exc=1, exccode=2, we=0, id=2. ADD with rd=0 → writeback_o=0.
- Hold result_ready_i=0 and issue 2 ADDs → count=2 and issue_ready_o=0. Raise ready for one cycle → the first result pops and issue_ready_o=1 the next cycle. Results come out in issue order, ids 0 then 1.
- Assert rst_ni low during the 2nd cycle of a MADD with 1 result queued → result_valid_o=0 and issue_ready_o=1 immediately. After release, no stale result appears.
